// File: rtl/riscv_defines.sv
// riscv_defines: shared definitions for the tag-exception controller.
//   tag_exc_state_e : FSM state encoding (IDLE, REQ, PEND)
//   CAUSE_*         : bit positions of the hit flags inside cause_o
package riscv_defines;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_PEND = 2'd2
  } tag_exc_state_e;

  localparam int CAUSE_S1 = 0;
  localparam int CAUSE_S2 = 1;
  localparam int CAUSE_D  = 2;

endpackage

// File: rtl/riscv_tag_exc_counter.sv
// riscv_tag_exc_counter: saturating event counter.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, clears count
//   inc   : add one this cycle (held at all-ones once reached)
//   count : current value, driven straight from the register
module riscv_tag_exc_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  logic [CNT_WIDTH-1:0] count_r;

  // Count increments, stopping at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {CNT_WIDTH{1'b0}};
    end else if (inc && (count_r != {CNT_WIDTH{1'b1}})) begin
      count_r <= count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/riscv_tag_exc_ctrl.sv
// riscv_tag_exc_ctrl: captures the first tag violation, requests a trap
// from the core controller and holds the record until software clears it.
//   clk, rst                    : clock, synchronous active-high reset
//   exception_i, valid_i        : violation flag, qualified by EX-stage valid
//   hit_s1_i/hit_s2_i/hit_d_i   : which check fired
//   pc_i, addr_i                : PC / load address of the EX instruction
//   exc_req_o, exc_ack_i        : trap request / acceptance handshake
//   clr_i                       : CSR write clearing the record and overflow
//   pending_o, cause_o, epc_o, eaddr_o : captured record
//   overflow_o                  : sticky, a violation arrived while busy
//   count_o                     : saturating count of qualified violations
module riscv_tag_exc_ctrl
  import riscv_defines::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 exception_i,
  input  logic                 hit_s1_i,
  input  logic                 hit_s2_i,
  input  logic                 hit_d_i,
  input  logic                 valid_i,
  input  logic [31:0]          pc_i,
  input  logic [31:0]          addr_i,
  output logic                 exc_req_o,
  input  logic                 exc_ack_i,
  input  logic                 clr_i,
  output logic                 pending_o,
  output logic [2:0]           cause_o,
  output logic [31:0]          epc_o,
  output logic [31:0]          eaddr_o,
  output logic                 overflow_o,
  output logic [CNT_WIDTH-1:0] count_o
);

  tag_exc_state_e state_r, state_nxt_s;
  logic           qual_s;
  logic           capture_s;
  logic           ovf_nxt_s;
  logic [2:0]     cause_s;
  logic           exc_req_r, pending_r, overflow_r;
  logic [2:0]     cause_r;
  logic [31:0]    epc_r, eaddr_r;

  assign qual_s = exception_i & valid_i;

  // Assemble the cause vector from the individual hit flags.
  always_comb begin
    cause_s           = 3'b000;
    cause_s[CAUSE_S1] = hit_s1_i;
    cause_s[CAUSE_S2] = hit_s2_i;
    cause_s[CAUSE_D]  = hit_d_i;
  end

  // Next state and capture decision. A clear coinciding with a new
  // violation in PEND retires the old record and starts a new one.
  always_comb begin
    state_nxt_s = state_r;
    capture_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (qual_s) begin
          state_nxt_s = ST_REQ;
          capture_s   = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (exc_ack_i) begin
          state_nxt_s = ST_PEND;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_PEND: begin
        if (clr_i && qual_s) begin
          state_nxt_s = ST_REQ;
          capture_s   = 1'b1;
        end else if (clr_i) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_PEND;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Overflow: clear wins; otherwise any violation seen while busy sets it.
  always_comb begin
    ovf_nxt_s = overflow_r;
    if (clr_i) begin
      ovf_nxt_s = 1'b0;
    end else if (qual_s && (state_r != ST_IDLE)) begin
      ovf_nxt_s = 1'b1;
    end else begin
      ovf_nxt_s = overflow_r;
    end
  end

  // State and output registers; request/pending are decoded from next state
  // so they come straight from flops with one cycle of latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      exc_req_r  <= 1'b0;
      pending_r  <= 1'b0;
      overflow_r <= 1'b0;
      cause_r    <= 3'b000;
      epc_r      <= 32'h0000_0000;
      eaddr_r    <= 32'h0000_0000;
    end else begin
      state_r    <= state_nxt_s;
      exc_req_r  <= (state_nxt_s == ST_REQ);
      pending_r  <= (state_nxt_s != ST_IDLE);
      overflow_r <= ovf_nxt_s;
      if (capture_s) begin
        cause_r <= cause_s;
        epc_r   <= pc_i;
        eaddr_r <= addr_i;
      end else begin
        cause_r <= cause_r;
        epc_r   <= epc_r;
        eaddr_r <= eaddr_r;
      end
    end
  end

  riscv_tag_exc_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_counter (
    .clk  (clk),
    .rst  (rst),
    .inc  (qual_s),
    .count(count_o)
  );

  assign exc_req_o  = exc_req_r;
  assign pending_o  = pending_r;
  assign overflow_o = overflow_r;
  assign cause_o    = cause_r;
  assign epc_o      = epc_r;
  assign eaddr_o    = eaddr_r;

endmodule

// File: doc/riscv_tag_exc_ctrl.md
RISCV_TAG_EXC_CTRL -- requirements
Module: riscv_tag_exc_ctrl

Interface
REQ-001 Parameter CNT_WIDTH, default 16: width of the tag-exception event counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 exception_i  input  1  tag violation flag from the tag check stage.
REQ-005 hit_s1_i / hit_s2_i / hit_d_i  input  1 each  which check fired (rs1, rs2, destination).
REQ-006 valid_i  input  1  EX-stage instruction valid and not stalled; exception_i is ignored when low.
REQ-007 pc_i  input  32  PC of the EX-stage instruction.
REQ-008 addr_i  input  32  load effective address of the EX-stage instruction.
REQ-009 exc_req_o  output  1  tag exception request to the core controller.
REQ-010 exc_ack_i  input  1  controller accepted the request (trap taken).
REQ-011 clr_i  input  1  CSR write clearing the pending record.
REQ-012 pending_o  output  1  a captured record is awaiting clear.
REQ-013 cause_o  output  3  captured {d,s2,s1} hit bits.
REQ-014 epc_o / eaddr_o  output  32 each  captured PC / address.
REQ-015 overflow_o  output  1  sticky: violation dropped while pending.
REQ-016 count_o  output  CNT_WIDTH  number of accepted violations.

Function
REQ-017 The block SHALL define qualified violation = exception_i & valid_i.
REQ-018 The FSM SHALL have states IDLE, REQ, PEND.
REQ-019 IDLE: on qualified violation -> REQ next cycle; cause_o, epc_o, eaddr_o latch the same-cycle inputs.
REQ-020 REQ: exc_req_o SHALL be 1 exactly while in REQ and SHALL stay high until exc_ack_i; on exc_ack_i -> PEND.
REQ-021 PEND: on clr_i -> IDLE; pending_o SHALL be 1 in REQ and PEND.
REQ-022 The latency from qualified violation to exc_req_o high SHALL be one cycle.
REQ-023 Captured fields SHALL NOT change in REQ or PEND except per REQ-026.
REQ-024 A qualified violation in REQ or PEND SHALL set overflow_o and SHALL NOT alter captured fields.
REQ-025 count_o SHALL increment by one on every qualified violation in any state, saturating at all-ones.
REQ-026 clr_i and qualified violation in the same PEND cycle: clear takes effect and the new violation is captured; next state REQ; overflow_o not set.
REQ-027 clr_i SHALL also clear overflow_o; clr_i in IDLE or REQ SHALL be ignored by the FSM and SHALL clear only overflow_o.
REQ-028 clr_i SHALL NOT reset count_o.
REQ-029 exc_ack_i outside REQ SHALL be ignored.

Reset
REQ-030 rst SHALL force state IDLE; exc_req_o, pending_o, overflow_o = 0; cause_o = 3'b000; epc_o, eaddr_o = 0; count_o = 0.
REQ-031 rst asserted during REQ or PEND SHALL abort the record with no further request; rst SHALL dominate all other inputs in the same cycle.

Structure
REQ-032 The FSM state enum and cause bit indices (CAUSE_S1=0, CAUSE_S2=1, CAUSE_D=2) SHALL reside in riscv_defines.
REQ-033 The saturating counter SHALL be a sub-module riscv_tag_exc_counter (parameter CNT_WIDTH; inputs clk, rst, inc; output count).
REQ-034 All outputs SHALL be driven directly from registers.

Verification
REQ-035 Violation with hit_s1_i=1, pc_i=0x0000_1000, addr_i=0x2000_0040 -> next cycle exc_req_o=1, cause_o=3'b001, epc_o=0x1000, eaddr_o=0x2000_0040, count_o=1.
REQ-036 exc_ack_i held low 5 cycles, then pulsed -> exc_req_o high those 5 cycles plus the ack cycle, then low; pending_o stays 1.
REQ-037 Second violation (hit_d_i, pc_i=0x1008) in PEND -> overflow_o=1, epc_o still 0x1000, count_o=2; clr_i -> IDLE, overflow_o=0.
REQ-038 clr_i and violation (hit_s2_i, pc_i=0x2000) same PEND cycle -> next cycle REQ, cause_o=3'b010, epc_o=0x2000, overflow_o=0.
REQ-039 exception_i=1 with valid_i=0 -> no request, count_o unchanged; CNT_WIDTH=4 with 20 violations -> count_o=4'hF.
REQ-040 rst pulsed while in REQ -> next cycle exc_req_o=0, pending_o=0, all fields and count_o zero.
